// File: rtl/sum_accumulator.sv
// Batch accumulator for the adder SUM stream: takes NB_SAMPLES unsigned sums
// over valid/ready and presents one wide, overflow-free total over valid/ready.
module sum_accumulator #(
  parameter  int DATA_WIDTH = 4,
  parameter  int NB_SAMPLES = 8,
  localparam int ACC_WIDTH  = DATA_WIDTH + 1 + $clog2(NB_SAMPLES),
  localparam int CNT_WIDTH  = $clog2(NB_SAMPLES + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  START_I,
  input  logic [DATA_WIDTH:0]   SUM_I,
  input  logic                  SUM_VALID_I,
  output logic                  SUM_READY_O,
  output logic [ACC_WIDTH-1:0]  ACC_O,
  output logic                  ACC_VALID_O,
  input  logic                  ACC_READY_I,
  output logic [CNT_WIDTH-1:0]  COUNT_O,
  output logic                  BUSY_O
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(NB_SAMPLES);

  state_t                 state_reg;
  logic [ACC_WIDTH-1:0]   acc_reg;
  logic [CNT_WIDTH-1:0]   cnt_reg;
  logic                   sum_ready_reg;
  logic                   acc_valid_reg;
  logic                   busy_reg;

  logic                   beat;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic [ACC_WIDTH-1:0]   acc_next;

  // A beat only exists while the registered ready is high, so sums offered
  // in IDLE or DONE are silently dropped.
  always_comb begin
    beat     = SUM_VALID_I & sum_ready_reg;
    cnt_next = cnt_reg + 1'b1;
    acc_next = acc_reg + ACC_WIDTH'(SUM_I);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      sum_ready_reg <= 1'b0;
      acc_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (START_I) begin
            acc_reg       <= '0;
            cnt_reg       <= '0;
            sum_ready_reg <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= ACCUM;
          end
        end

        ACCUM: begin
          if (beat) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_next;
            if (cnt_next == CNT_FULL) begin
              sum_ready_reg <= 1'b0;
              acc_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end
        end

        DONE: begin
          // Total and count stay frozen until downstream takes the result.
          if (ACC_READY_I) begin
            acc_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end

        default: begin
          sum_ready_reg <= 1'b0;
          acc_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign SUM_READY_O = sum_ready_reg;
  assign ACC_O       = acc_reg;
  assign ACC_VALID_O = acc_valid_reg;
  assign COUNT_O     = cnt_reg;
  assign BUSY_O      = busy_reg;

endmodule

// File: tb/tb_sum_accumulator.sv
// Randomized scoreboard bench: instance a (NB_SAMPLES=8) and instance b
// (NB_SAMPLES=1); expected totals are queued by stimulus and popped by monitors.
module tb_sum_accumulator;

  logic clk;
  logic rst_n;

  logic       a_start, a_sv, a_sr, a_av, a_ar, a_busy;
  logic [4:0] a_sum;
  logic [7:0] a_acc;
  logic [3:0] a_cnt;

  logic       b_start, b_sv, b_sr, b_av, b_ar, b_busy;
  logic [4:0] b_sum;
  logic [4:0] b_acc;
  logic [0:0] b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_a_acc[$];
  int exp_a_cnt[$];
  int exp_b_acc[$];
  int exp_b_cnt[$];

  sum_accumulator #(.DATA_WIDTH(4), .NB_SAMPLES(8)) dut_a (
    .clock(clk), .reset_n(rst_n), .START_I(a_start), .SUM_I(a_sum),
    .SUM_VALID_I(a_sv), .SUM_READY_O(a_sr), .ACC_O(a_acc),
    .ACC_VALID_O(a_av), .ACC_READY_I(a_ar), .COUNT_O(a_cnt), .BUSY_O(a_busy)
  );

  sum_accumulator #(.DATA_WIDTH(4), .NB_SAMPLES(1)) dut_b (
    .clock(clk), .reset_n(rst_n), .START_I(b_start), .SUM_I(b_sum),
    .SUM_VALID_I(b_sv), .SUM_READY_O(b_sr), .ACC_O(b_acc),
    .ACC_VALID_O(b_av), .ACC_READY_I(b_ar), .COUNT_O(b_cnt), .BUSY_O(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitors: pop one expected result each time a result is first presented.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (a_av && !prev) begin
        if (exp_a_acc.size() == 0) begin
          chk("a_unexpected_valid", 1, 0);
        end else begin
          chk("a_sb_acc", a_acc, exp_a_acc.pop_front());
          chk("a_sb_cnt", a_cnt, exp_a_cnt.pop_front());
        end
      end
      prev = a_av;
    end
  end

  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (b_av && !prev) begin
        if (exp_b_acc.size() == 0) begin
          chk("b_unexpected_valid", 1, 0);
        end else begin
          chk("b_sb_acc", b_acc, exp_b_acc.pop_front());
          chk("b_sb_cnt", b_cnt, exp_b_cnt.pop_front());
        end
      end
      prev = b_av;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_a_acc"}, a_acc, 0);
    chk({nm, "_a_cnt"}, a_cnt, 0);
    chk({nm, "_a_ready"}, a_sr, 0);
    chk({nm, "_a_valid"}, a_av, 0);
    chk({nm, "_a_busy"}, a_busy, 0);
    chk({nm, "_b_acc"}, b_acc, 0);
    chk({nm, "_b_valid"}, b_av, 0);
    chk({nm, "_b_busy"}, b_busy, 0);
  endtask

  // mode 0: all 5; mode 1: all 30; mode 2: 1..8 with alternating bubbles;
  // mode 3: random values, random bubbles, random START noise.
  task automatic a_batch(input int mode, input int bp);
    int total;
    int v;
    int nb;
    total = 0;
    // START cycle also offers a sum that must be dropped (not ready in IDLE)
    a_start = 1'b1;
    a_sv    = 1'b1;
    a_sum   = 5'($urandom_range(1, 31));
    @(posedge clk); #1;
    a_start = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
    a_sv    = 1'b0;
    chk("start_acc_clear", a_acc, 0);
    chk("start_cnt_clear", a_cnt, 0);
    chk("accum_ready", a_sr, 1);
    chk("accum_busy", a_busy, 1);
    for (int i = 0; i < 8; i++) begin
      if (mode == 2)      nb = (i > 0) ? 1 : 0;
      else if (mode == 3) nb = $urandom_range(0, 2);
      else                nb = 0;
      for (int b = 0; b < nb; b++) begin
        a_sv  = 1'b0;
        a_sum = 5'($urandom_range(0, 31));
        @(posedge clk); #1;
        chk("bubble_cnt", a_cnt, i);
        chk("bubble_acc", a_acc, total);
      end
      case (mode)
        0:       v = 5;
        1:       v = 30;
        2:       v = i + 1;
        default: v = $urandom_range(0, 31);
      endcase
      a_sum = 5'(v);
      a_sv  = 1'b1;
      total += v;
      if (i == 7) begin
        exp_a_acc.push_back(total);
        exp_a_cnt.push_back(8);
      end
      if (mode == 3) a_start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("beat_cnt", a_cnt, i + 1);
      chk("beat_acc", a_acc, total);
    end
    a_sv    = 1'b0;
    a_start = 1'b0;
    chk("valid_latency", a_av, 1);
    chk("done_ready", a_sr, 0);
    for (int c = 0; c < bp; c++) begin
      a_start = 1'($urandom_range(0, 1));
      a_sv    = 1'b1;
      a_sum   = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
      chk("bp_valid", a_av, 1);
      chk("bp_acc", a_acc, total);
      chk("bp_cnt", a_cnt, 8);
      chk("bp_ready", a_sr, 0);
      chk("bp_busy", a_busy, 1);
    end
    // START in the handshake cycle must be ignored
    a_sv    = 1'b0;
    a_ar    = 1'b1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_ar    = 1'b0;
    a_start = 1'b0;
    chk("release_valid", a_av, 0);
    chk("release_busy", a_busy, 0);
    chk("idle_ready", a_sr, 0);
    @(posedge clk); #1;
    chk("idle_stays", a_busy, 0);
  endtask

  task automatic a_abort_by_reset();
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_sum = 5'($urandom_range(1, 31));
      a_sv  = 1'b1;
      @(posedge clk); #1;
    end
    a_sv = 1'b0;
    chk("abort_pre_cnt", a_cnt, 3);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic b_batch(input int v, input bit start_noise);
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = start_noise;
    chk("b_start_acc", b_acc, 0);
    chk("b_start_cnt", b_cnt, 0);
    chk("b_ready", b_sr, 1);
    b_sum = 5'(v);
    b_sv  = 1'b1;
    exp_b_acc.push_back(v);
    exp_b_cnt.push_back(1);
    @(posedge clk); #1;
    b_sv = 1'b0;
    chk("b_valid_latency", b_av, 1);
    chk("b_done_acc", b_acc, v);
    chk("b_done_cnt", b_cnt, 1);
    chk("b_done_ready", b_sr, 0);
    @(posedge clk); #1;
    b_start = 1'b0;
    chk("b_hold_acc", b_acc, v);
    b_ar = 1'b1;
    @(posedge clk); #1;
    b_ar = 1'b0;
    chk("b_release_valid", b_av, 0);
    chk("b_release_busy", b_busy, 0);
  endtask

  initial begin
    rst_n   = 1'b1;
    a_start = 1'b0; a_sv = 1'b0; a_sum = '0; a_ar = 1'b0;
    b_start = 1'b0; b_sv = 1'b0; b_sum = '0; b_ar = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", a_busy, 0);

    a_batch(0, 0);
    a_batch(1, 0);
    a_batch(2, 0);
    a_batch(3, 5);
    a_abort_by_reset();
    a_batch(0, 2);

    b_batch(31, 1'b1);
    for (int k = 0; k < 4; k++) b_batch($urandom_range(0, 31), 1'($urandom_range(0, 1)));

    for (int k = 0; k < 8; k++) a_batch(3, $urandom_range(0, 4));

    repeat (3) @(posedge clk);
    #1;
    chk("a_pending_results", exp_a_acc.size(), 0);
    chk("b_pending_results", exp_b_acc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
